// File: rtl/axi4_lite_cmd_arbiter.sv
// rtl/axi4_lite_cmd_arbiter.sv - round-robin arbiter sharing one AXI4-Lite master command port
module axi4_lite_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      cmd_valid,
    output logic                      cmd_write,
    output logic [ADDR_W-1:0]         cmd_addr,
    output logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W-1:0]         cmd_rdata,
    input  logic                      cmd_done,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      spurious
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {ST_ARB, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_q;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic             accept;
    logic [WD_W-1:0]  wd_cnt;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    assign accept    = (state_q == ST_ARB) && win_found;
    assign req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;
    assign cmd_valid = (state_q == ST_ISSUE);
    assign busy      = (state_q != ST_ARB);
    assign rsp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign rsp_rdata = (state_q == ST_RESP) ? cmd_rdata : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:   if (win_found) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (cmd_done) state_d = ST_RESP;
            ST_RESP:  state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_ARB;
            rr_ptr      <= '0;
            grant_q     <= '0;
            cmd_write   <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            spurious    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_done && state_q != ST_WAIT) spurious <= 1'b1;
            case (state_q)
                ST_ARB: begin
                    if (accept) begin
                        grant_q   <= win_idx;
                        cmd_write <= req_write[win_idx];
                        cmd_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
                        cmd_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
                        rr_ptr    <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A completion in the same cycle as the limit takes precedence over the error.
                    if (cmd_done) begin
                        wd_cnt <= '0;
                    end else if (TIMEOUT != 0 && wd_cnt == WD_MAX) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_cmd_arbiter.sv
// tb/tb_axi4_lite_cmd_arbiter.sv - self-checking bench for axi4_lite_cmd_arbiter
module tb_axi4_lite_cmd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 16;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, cmd_wdata, cmd_rdata;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_valid, cmd_write, cmd_done, busy, timeout_err, spurious;

    axi4_lite_cmd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_rdata(cmd_rdata), .cmd_done(cmd_done),
        .busy(busy), .timeout_err(timeout_err), .spurious(spurious)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [N-1:0] mask;
        logic         wr;
        logic [31:0]  addr;
        logic [63:0]  wdata;
        logic [63:0]  rdata;
        int           lat;
        int           g;
    } vec_t;

    typedef struct {
        int          g;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
    } cmd_exp_t;

    typedef struct {
        int          g;
        logic        wr;
        logic [63:0] rdata;
    } rsp_exp_t;

    cmd_exp_t cmd_q[$];
    rsp_exp_t rsp_q[$];
    vec_t     vecs[13];
    int       n_cmp = 0;
    int       n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Requester i sees the vector's address offset by i*0x10 and data xor i.
    task automatic drive_reqs(input vec_t v);
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = v.mask[i];
            req_write[i]            = v.wr;
            req_addr[i*AW +: AW]    = v.addr + 32'(i) * 32'h10;
            req_wdata[i*DW +: DW]   = v.wdata ^ 64'(i);
        end
    endtask

    task automatic start_txn(input vec_t v);
        cmd_exp_t c;
        @(negedge ACLK);
        drive_reqs(v);
        #1;
        chk("req_ready", 64'(req_ready), 64'(4'b0001 << v.g));
        cmd_q.push_back('{v.g, v.wr, v.addr + 32'(v.g) * 32'h10, v.wdata ^ 64'(v.g)});
        @(negedge ACLK);
        req_valid = '0;
        chk("cmd_valid_issue", 64'(cmd_valid), 64'd1);
        if (cmd_q.size() > 0) begin
            c = cmd_q.pop_front();
            chk("cmd_addr", 64'(cmd_addr), 64'(c.addr));
            chk("cmd_write", 64'(cmd_write), 64'(c.wr));
            chk("cmd_wdata", cmd_wdata, c.wdata);
        end
    endtask

    task automatic finish_txn(input vec_t v);
        rsp_exp_t r;
        cmd_done = 1'b1;
        rsp_q.push_back('{v.g, v.wr, v.rdata});
        @(negedge ACLK);
        cmd_done  = 1'b0;
        cmd_rdata = v.rdata;
        #1;
        r = rsp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << r.g));
        if (!r.wr) chk("rsp_rdata", rsp_rdata, r.rdata);
        @(negedge ACLK);
        cmd_rdata = '0;
        chk("busy_after_resp", 64'(busy), 64'd0);
        chk("rsp_valid_after", 64'(rsp_valid), 64'd0);
    endtask

    task automatic run_txn(input vec_t v);
        start_txn(v);
        for (int k = 0; k < v.lat; k++) begin
            @(negedge ACLK);
            chk("cmd_valid_wait", 64'(cmd_valid), 64'd0);
        end
        finish_txn(v);
    endtask

    initial begin
        vec_t v;
        ARESETn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        cmd_rdata = '0;
        cmd_done  = 1'b0;

        vecs[0] = '{4'b0001, 1'b1, 32'h100, 64'hDEADBEEF_CAFEF00D, 64'h0, 1, 0};
        vecs[1] = '{4'b0100, 1'b0, 32'h1E0, 64'h0, 64'h11223344_55667788, 3, 2};
        vecs[2] = '{4'b0010, 1'b0, 32'h300, 64'h0, 64'h0BAD_F00D_1234_0002, 2, 1};
        vecs[3] = '{4'b0100, 1'b1, 32'h400, 64'h5555_AAAA_0000_0003, 64'h0, 1, 2};
        vecs[4] = '{4'b1000, 1'b0, 32'h500, 64'h0, 64'hFFFF_0000_FFFF_0004, 2, 3};
        for (int i = 5; i < 13; i++)
            vecs[i] = '{4'b1111, 1'(i % 2), 32'h1000 * 32'(i), 64'hC0DE_0000_0000_0000 | 64'(i),
                        64'hA5A5_0000_0000_0000 | 64'(i), 1 + (i % 3), (i - 5) % 4};

        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_flags", 64'({timeout_err, spurious}), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        repeat (2) @(negedge ACLK);
        chk("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 13; i++) run_txn(vecs[i]);

        // Master never answers: watchdog trips, transaction still completes late.
        v = '{4'b0001, 1'b0, 32'h700, 64'h0, 64'h7777_8888_9999_AAAA, 0, 0};
        start_txn(v);
        repeat (10) @(negedge ACLK);
        chk("timeout_early", 64'(timeout_err), 64'd0);
        repeat (30) @(negedge ACLK);
        chk("timeout_set", 64'(timeout_err), 64'd1);
        chk("timeout_busy", 64'(busy), 64'd1);
        chk("timeout_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("timeout_cmd_addr", 64'(cmd_addr), 64'h700);
        finish_txn(v);
        chk("timeout_sticky", 64'(timeout_err), 64'd1);
        chk("spurious_clear", 64'(spurious), 64'd0);

        // Reset during WAIT, then a stray completion.
        v = '{4'b1000, 1'b1, 32'h800, 64'h1234, 64'h0, 0, 3};
        start_txn(v);
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_timeout", 64'(timeout_err), 64'd0);
        chk("midrst_cmd_addr", 64'(cmd_addr), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        cmd_done = 1'b1;
        @(negedge ACLK);
        cmd_done = 1'b0;
        #1;
        chk("stray_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("stray_spurious", 64'(spurious), 64'd1);
        chk("stray_busy", 64'(busy), 64'd0);

        // Pointer returned to 0 by reset.
        run_txn('{4'b1111, 1'b0, 32'h900, 64'h0, 64'h9999_0000_0000_0009, 1, 0});

        n_cmp++;
        if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: cmd %0d rsp %0d left, expected 0 0", cmd_q.size(), rsp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
